// File: rtl/rank_score_classifier.sv
// rank_score_classifier: gathers one score per rank kernel, scans for best and runner-up, emits rank/score/margin.
// Optional RANK_REJECT_EN: weak, ambiguous or under-populated matches report rank_out = 0.
module rank_score_classifier #(
    parameter int NUM_KERNELS      = 13,
    parameter int SCORE_WIDTH      = 11,
    parameter int TIMEOUT_CYCLES   = 2000000,
    parameter int REJECT_THRESHOLD = 600
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_start,
    input  logic [NUM_KERNELS*SCORE_WIDTH-1:0] score_in,
    input  logic [NUM_KERNELS-1:0]             score_valid,
    output logic [3:0]                         rank_out,
    output logic [SCORE_WIDTH-1:0]             best_score,
    output logic [SCORE_WIDTH-1:0]             margin,
    output logic                               result_valid,
    output logic                               busy,
    output logic                               overrun
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef RANK_REJECT_EN
    localparam bit REJECT_EN = 1'b1;
`else
    localparam bit REJECT_EN = 1'b0;
`endif
    typedef enum logic [1:0] {COLLECT, SCAN, EMIT} state_t;
    state_t                 r_state;
    logic [NUM_KERNELS-1:0] r_received;
    logic [SCORE_WIDTH-1:0] r_score [NUM_KERNELS];
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_idx;
    logic [3:0]             r_best_idx;
    logic [SCORE_WIDTH-1:0] r_best;
    logic [SCORE_WIDTH-1:0] r_second;
    logic [3:0]             r_rank;
    logic [SCORE_WIDTH-1:0] r_best_score;
    logic [SCORE_WIDTH-1:0] r_margin;
    logic                   r_result_valid;
    logic                   r_busy;
    logic                   r_overrun;
    logic [NUM_KERNELS-1:0] w_recv_next;
    logic                   w_timeout;
    logic [SCORE_WIDTH-1:0] w_margin;
    logic                   w_reject;
    assign w_recv_next = r_received | score_valid;
    assign w_timeout   = (r_received != '0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_margin    = r_second - r_best;
    // Fewer than two received kernels can only happen on a timeout-forced scan
    assign w_reject    = REJECT_EN && ((r_best > SCORE_WIDTH'(REJECT_THRESHOLD)) ||
                         (w_margin == '0) || ($countones(r_received) < 2));
    assign rank_out     = r_rank;
    assign best_score   = r_best_score;
    assign margin       = r_margin;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= COLLECT;
            r_received     <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) r_score[k] <= '1;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_best_idx     <= '0;
            r_best         <= '1;
            r_second       <= '1;
            r_rank         <= '0;
            r_best_score   <= '0;
            r_margin       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (frame_start) begin
            r_state        <= COLLECT;
            r_received     <= score_valid;
            for (int k = 0; k < NUM_KERNELS; k++)
                r_score[k] <= score_valid[k] ? score_in[k*SCORE_WIDTH +: SCORE_WIDTH] : '1;
            r_cnt          <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                COLLECT: begin
                    for (int k = 0; k < NUM_KERNELS; k++)
                        if (score_valid[k]) r_score[k] <= score_in[k*SCORE_WIDTH +: SCORE_WIDTH];
                    r_received <= w_recv_next;
                    if (r_received != '0) r_cnt <= r_cnt + 1'b1;
                    if ((&w_recv_next) || w_timeout) begin
                        r_state  <= SCAN;
                        r_busy   <= 1'b1;
                        r_idx    <= '0;
                        r_best   <= '1;
                        r_second <= '1;
                    end
                end
                SCAN: begin
                    if (score_valid != '0) r_overrun <= 1'b1;
                    // Scores shift toward slot 0 so the comparator always reads one fixed entry
                    for (int k = 0; k < NUM_KERNELS - 1; k++) r_score[k] <= r_score[k+1];
                    r_score[NUM_KERNELS-1] <= '1;
                    if (r_score[0] < r_best) begin
                        r_second   <= r_best;
                        r_best     <= r_score[0];
                        r_best_idx <= r_idx;
                    end else if (r_score[0] < r_second) begin
                        r_second <= r_score[0];
                    end
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'(NUM_KERNELS - 1)) r_state <= EMIT;
                end
                EMIT: begin
                    if (score_valid != '0) r_overrun <= 1'b1;
                    r_result_valid <= 1'b1;
                    r_rank         <= w_reject ? 4'd0 : r_best_idx + 4'd1;
                    r_best_score   <= r_best;
                    r_margin       <= w_margin;
                    r_received     <= '0;
                    for (int k = 0; k < NUM_KERNELS; k++) r_score[k] <= '1;
                    r_cnt          <= '0;
                    r_busy         <= 1'b0;
                    r_state        <= COLLECT;
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule
